// File: rtl/led_pattern_counter.sv
// ----------------------------------------------------------------------------
// led_pattern_counter
//   Parametrised LED driver counter with prescaler, four count/pattern modes,
//   synchronous load and registered status strobes.
//
// Parameters
//   WIDTH      LED/counter width in bits (>= 2)
//   DIV        enabled clocks per step (>= 1)
//   RESET_VAL  LEDS value on reset
//
// Ports
//   CLK       in   system clock, rising edge
//   RESET     in   asynchronous, active-high reset
//   EN        in   count enable; low freezes prescaler and LEDS
//   MODE      in   00 up, 01 down, 10 rotate-left, 11 bounce
//   LOAD      in   synchronous load of LOAD_VAL (independent of EN)
//   LOAD_VAL  in   value loaded on LOAD
//   LEDS      out  registered counter/pattern value
//   STEP      out  1-cycle pulse with each step-driven LEDS update
//   WRAP      out  1-cycle pulse with the update that completes a period
//   CHANGED   out  1-cycle pulse, the cycle after LEDS changed value
//
// Build option
//   LEDCNT_SATURATE_EN : up/down modes saturate at all-ones/zero and never
//                        raise WRAP; rotate and bounce are unaffected.
// ----------------------------------------------------------------------------
module led_pattern_counter #(
    parameter int unsigned           WIDTH     = 32,
    parameter int unsigned           DIV       = 1,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    output logic [WIDTH-1:0] LEDS,
    output logic             STEP,
    output logic             WRAP,
    output logic             CHANGED
);

    localparam int unsigned      PW        = $clog2(DIV) + 1;
    localparam logic [PW-1:0]    PCNT_LAST = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] LSB_ONLY  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MSB_ONLY  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_ROTATE = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    logic [WIDTH-1:0] r_leds;
    logic [WIDTH-1:0] r_prev;
    logic [PW-1:0]    r_pcnt;
    dir_t             r_dir;
    logic             r_step;
    logic             r_wrap;
    logic             r_changed;

    logic             w_step;
    logic             w_onehot;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_next_leds;
    dir_t             w_next_dir;
    logic             w_next_wrap;
    mode_t            w_mode;

    assign w_mode   = mode_t'(MODE);
    assign w_step   = EN && (r_pcnt == PCNT_LAST);
    // Power-of-two test: exactly one bit set.
    assign w_onehot = (r_leds != '0) && ((r_leds & (r_leds - LSB_ONLY)) == '0);
    assign w_shl    = r_leds << 1;
    assign w_shr    = r_leds >> 1;

    // Value, direction and wrap flag that a step would produce this cycle.
    always_comb begin
        w_next_leds = r_leds;
        w_next_dir  = r_dir;
        w_next_wrap = 1'b0;
        unique case (w_mode)
            MODE_UP: begin
`ifdef LEDCNT_SATURATE_EN
                if (r_leds != '1)
                    w_next_leds = r_leds + LSB_ONLY;
`else
                w_next_leds = r_leds + LSB_ONLY;
                w_next_wrap = (r_leds == '1);
`endif
            end
            MODE_DOWN: begin
`ifdef LEDCNT_SATURATE_EN
                if (r_leds != '0)
                    w_next_leds = r_leds - LSB_ONLY;
`else
                w_next_leds = r_leds - LSB_ONLY;
                w_next_wrap = (r_leds == '0);
`endif
            end
            MODE_ROTATE: begin
                if (r_leds == '0) begin
                    // An empty pattern would rotate forever as zero; seed it.
                    w_next_leds = LSB_ONLY;
                end else begin
                    w_next_leds = {r_leds[WIDTH-2:0], r_leds[WIDTH-1]};
                    w_next_wrap = r_leds[WIDTH-1];
                end
            end
            MODE_BOUNCE: begin
                if (!w_onehot) begin
                    // Re-synchronise any non-walker pattern to the start.
                    w_next_leds = LSB_ONLY;
                    w_next_dir  = DIR_LEFT;
                end else if (r_dir == DIR_LEFT) begin
                    w_next_leds = w_shl;
                    if (w_shl == MSB_ONLY)
                        w_next_dir = DIR_RIGHT;
                end else begin
                    w_next_leds = w_shr;
                    if (w_shr == LSB_ONLY) begin
                        w_next_dir  = DIR_LEFT;
                        w_next_wrap = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_leds    <= RESET_VAL;
            r_prev    <= RESET_VAL;
            r_pcnt    <= '0;
            r_dir     <= DIR_LEFT;
            r_step    <= 1'b0;
            r_wrap    <= 1'b0;
            r_changed <= 1'b0;
        end else begin
            // Change detection runs every cycle, independent of load/step.
            r_prev    <= r_leds;
            r_changed <= (r_leds != r_prev);
            r_step    <= 1'b0;
            r_wrap    <= 1'b0;
            if (LOAD) begin
                r_leds <= LOAD_VAL;
                r_pcnt <= '0;
                r_dir  <= DIR_LEFT;
            end else if (w_step) begin
                r_leds <= w_next_leds;
                r_dir  <= w_next_dir;
                r_pcnt <= '0;
                r_step <= 1'b1;
                r_wrap <= w_next_wrap;
            end else if (EN) begin
                r_pcnt <= r_pcnt + 1'b1;
            end
        end
    end

    assign LEDS    = r_leds;
    assign STEP    = r_step;
    assign WRAP    = r_wrap;
    assign CHANGED = r_changed;

endmodule

// File: tb/tb_led_pattern_counter.sv
// ----------------------------------------------------------------------------
// tb_led_pattern_counter
//   Self-checking bench for led_pattern_counter at WIDTH=4. One instance uses
//   DIV=3 (table-driven vectors plus reset sequence), a second uses DIV=1
//   (down-wrap and bounce sequences). Both share all inputs.
// ----------------------------------------------------------------------------
module tb_led_pattern_counter;

    localparam logic [1:0] UP = 2'b00, DN = 2'b01, ROT = 2'b10, BNC = 2'b11;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       EN;
    logic [1:0] MODE;
    logic       LOAD;
    logic [3:0] LOAD_VAL;

    logic [3:0] leds3, leds1;
    logic       step3, wrap3, chg3;
    logic       step1, wrap1, chg1;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    led_pattern_counter #(.WIDTH(4), .DIV(3), .RESET_VAL(4'h0)) dut (
        .CLK(CLK), .RESET(RESET), .EN(EN), .MODE(MODE), .LOAD(LOAD),
        .LOAD_VAL(LOAD_VAL), .LEDS(leds3), .STEP(step3), .WRAP(wrap3),
        .CHANGED(chg3)
    );

    led_pattern_counter #(.WIDTH(4), .DIV(1), .RESET_VAL(4'h0)) dut1 (
        .CLK(CLK), .RESET(RESET), .EN(EN), .MODE(MODE), .LOAD(LOAD),
        .LOAD_VAL(LOAD_VAL), .LEDS(leds1), .STEP(step1), .WRAP(wrap1),
        .CHANGED(chg1)
    );

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic       load;
        logic [3:0] val;
        logic [3:0] leds;
        logic       step;
        logic       wrap;
        logic       chg;
    } vec_t;

    vec_t tbl[44];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic en, input logic [1:0] mode, input logic load,
                         input logic [3:0] val);
        EN = en; MODE = mode; LOAD = load; LOAD_VAL = val;
    endtask

    // Advance one edge and sample just after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // {en, mode, load, val, leds, step, wrap, changed} after each edge (DIV=3)
        tbl[0]  = '{1'b1, UP,  1'b1, 4'hE, 4'hE, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, UP,  1'b0, 4'h0, 4'hE, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, UP,  1'b0, 4'h0, 4'hE, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, UP,  1'b0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, UP,  1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, UP,  1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, UP,  1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, UP,  1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, UP,  1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, UP,  1'b1, 4'h5, 4'h5, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, UP,  1'b0, 4'h0, 4'h5, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b1, UP,  1'b0, 4'h0, 4'h5, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, UP,  1'b0, 4'h0, 4'h6, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, UP,  1'b1, 4'h5, 4'h5, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b0, UP,  1'b0, 4'h0, 4'h5, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, UP,  1'b1, 4'h5, 4'h5, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{1'b0, UP,  1'b0, 4'h0, 4'h5, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{1'b1, UP,  1'b0, 4'h0, 4'h5, 1'b0, 1'b0, 1'b0};
        for (int i = 18; i <= 22; i++)
            tbl[i] = '{1'b0, UP, 1'b0, 4'h0, 4'h5, 1'b0, 1'b0, 1'b0};
        tbl[23] = '{1'b1, UP,  1'b0, 4'h0, 4'h5, 1'b0, 1'b0, 1'b0};
        tbl[24] = '{1'b1, UP,  1'b0, 4'h0, 4'h6, 1'b1, 1'b0, 1'b0};
        tbl[25] = '{1'b1, UP,  1'b0, 4'h0, 4'h6, 1'b0, 1'b0, 1'b1};
        tbl[26] = '{1'b0, ROT, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
        tbl[27] = '{1'b1, ROT, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1};
        tbl[28] = '{1'b1, ROT, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
        tbl[29] = '{1'b1, ROT, 1'b0, 4'h0, 4'h1, 1'b1, 1'b0, 1'b0};
        tbl[30] = '{1'b1, ROT, 1'b0, 4'h0, 4'h1, 1'b0, 1'b0, 1'b1};
        tbl[31] = '{1'b1, ROT, 1'b0, 4'h0, 4'h1, 1'b0, 1'b0, 1'b0};
        tbl[32] = '{1'b1, ROT, 1'b0, 4'h0, 4'h2, 1'b1, 1'b0, 1'b0};
        tbl[33] = '{1'b1, ROT, 1'b1, 4'h8, 4'h8, 1'b0, 1'b0, 1'b1};
        tbl[34] = '{1'b1, ROT, 1'b0, 4'h0, 4'h8, 1'b0, 1'b0, 1'b1};
        tbl[35] = '{1'b1, ROT, 1'b0, 4'h0, 4'h8, 1'b0, 1'b0, 1'b0};
        tbl[36] = '{1'b1, ROT, 1'b0, 4'h0, 4'h1, 1'b1, 1'b1, 1'b0};
        tbl[37] = '{1'b1, UP,  1'b0, 4'h0, 4'h1, 1'b0, 1'b0, 1'b1};
        tbl[38] = '{1'b1, DN,  1'b0, 4'h0, 4'h1, 1'b0, 1'b0, 1'b0};
        tbl[39] = '{1'b1, DN,  1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0};
        tbl[40] = '{1'b1, DN,  1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1};
        tbl[41] = '{1'b1, DN,  1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
        tbl[42] = '{1'b1, DN,  1'b0, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0};
        tbl[43] = '{1'b1, DN,  1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b1};

        // Power-on reset
        RESET = 1'b1;
        drive(1'b0, UP, 1'b0, 4'h0);
        #12;
        chk("reset_leds",    leds3, 4'h0);
        chk("reset_step",    {3'b0, step3}, 4'h0);
        chk("reset_wrap",    {3'b0, wrap3}, 4'h0);
        chk("reset_changed", {3'b0, chg3},  4'h0);
        chk("reset_leds1",   leds1, 4'h0);
        @(negedge CLK);
        RESET = 1'b0;

        // Table-driven vectors on the DIV=3 instance
        for (int i = 0; i < 44; i++) begin
            drive(tbl[i].en, tbl[i].mode, tbl[i].load, tbl[i].val);
            tick();
            chk($sformatf("vec%0d_leds", i),    leds3,          tbl[i].leds);
            chk($sformatf("vec%0d_step", i),    {3'b0, step3},  {3'b0, tbl[i].step});
            chk($sformatf("vec%0d_wrap", i),    {3'b0, wrap3},  {3'b0, tbl[i].wrap});
            chk($sformatf("vec%0d_changed", i), {3'b0, chg3},   {3'b0, tbl[i].chg});
        end

        // Down mode from 0 with DIV=1: F, E, D; WRAP only on 0->F
        drive(1'b1, DN, 1'b1, 4'h0);
        tick();
        chk("down_load", leds1, 4'h0);
        drive(1'b1, DN, 1'b0, 4'h0);
        tick();
        chk("down_F",      leds1, 4'hF);
        chk("down_F_wrap", {3'b0, wrap1}, 4'h1);
        chk("down_F_step", {3'b0, step1}, 4'h1);
        tick();
        chk("down_E",      leds1, 4'hE);
        chk("down_E_wrap", {3'b0, wrap1}, 4'h0);
        tick();
        chk("down_D",      leds1, 4'hD);
        chk("down_D_wrap", {3'b0, wrap1}, 4'h0);

        // Bounce from a non-one-hot load with DIV=1
        drive(1'b1, BNC, 1'b1, 4'b0110);
        tick();
        chk("bnc_load", leds1, 4'b0110);
        drive(1'b1, BNC, 1'b0, 4'h0);
        begin
            logic [3:0] exp_b[8];
            exp_b = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                      4'b0100, 4'b0010, 4'b0001, 4'b0010};
            for (int k = 0; k < 8; k++) begin
                tick();
                chk($sformatf("bnc%0d_leds", k), leds1, exp_b[k]);
                chk($sformatf("bnc%0d_wrap", k), {3'b0, wrap1}, (k == 6) ? 4'h1 : 4'h0);
                chk($sformatf("bnc%0d_step", k), {3'b0, step1}, 4'h1);
            end
        end

        // Asynchronous reset mid-cycle on the DIV=3 instance
        drive(1'b1, UP, 1'b1, 4'h9);
        tick();
        drive(1'b1, UP, 1'b0, 4'h0);
        tick();
        chk("pre_rst_leds",    leds3, 4'h9);
        chk("pre_rst_changed", {3'b0, chg3}, 4'h1);
        RESET = 1'b1;
        #1;
        chk("async_rst_leds",    leds3, 4'h0);
        chk("async_rst_step",    {3'b0, step3}, 4'h0);
        chk("async_rst_wrap",    {3'b0, wrap3}, 4'h0);
        chk("async_rst_changed", {3'b0, chg3},  4'h0);
        #2;
        RESET = 1'b0;
        tick();
        chk("post_rst1_leds", leds3, 4'h0);
        chk("post_rst1_step", {3'b0, step3}, 4'h0);
        tick();
        chk("post_rst2_leds", leds3, 4'h0);
        chk("post_rst2_step", {3'b0, step3}, 4'h0);
        tick();
        chk("post_rst3_leds", leds3, 4'h1);
        chk("post_rst3_step", {3'b0, step3}, 4'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
